// File: rtl/sprite_draw_controller.sv
// sprite_draw_controller: latches player/enemy/bullet move pulses and serialises one redraw
// job per sprite into a single-pixel plot stream. A job erases the old footprint with
// BG_COLOUR, then draws the new one.
// Optional build macro: SCREEN_CLEAR_EN sweeps the whole 160x120 screen with BG_COLOUR after
// reset/load_level before any sprite job runs.
module sprite_draw_controller #(
    parameter logic [2:0]  PLAYER_COLOUR = 3'b010,
    parameter logic [2:0]  BULLET_COLOUR = 3'b110,
    parameter logic [2:0]  BG_COLOUR     = 3'b000,
    parameter int unsigned PLAYER_W      = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load_level,
    input  logic       player_move,
    input  logic [7:0] playerX,
    input  logic [6:0] playerY,
    input  logic       enemy_move,
    input  logic [7:0] enemyX,
    input  logic [6:0] enemyY,
    input  logic [2:0] enemy_width,
    input  logic [2:0] enemy_color,
    input  logic       bullet_move,
    input  logic [7:0] bulletX,
    input  logic [6:0] bulletY,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);
    localparam logic [1:0] SP_PLAYER = 2'd0;
    localparam logic [1:0] SP_ENEMY  = 2'd1;
    localparam logic [1:0] SP_BULLET = 2'd2;
    localparam logic [2:0] PW        = 3'(PLAYER_W);
    localparam logic [8:0] SCREEN_W  = 9'd160;
    localparam logic [7:0] SCREEN_H  = 8'd120;

    typedef enum logic [2:0] {StIdle, StSnap, StErase, StDraw, StClear} state_e;

    state_e     state_q;
    // Per-sprite flags are 4 wide so a 2-bit sprite index never selects out of range.
    logic [3:0] pending_q, first_draw_q;
    logic [1:0] job_id_q;
    logic [7:0] job_x_q;
    logic [6:0] job_y_q;
    logic [2:0] job_w_q, job_col_q;
    logic [7:0] old_x_q [4];
    logic [6:0] old_y_q [4];
    logic [2:0] old_w_q [4];
    logic [2:0] dx_q, dy_q;
`ifdef SCREEN_CLEAR_EN
    logic [7:0] clr_x_q;
    logic [6:0] clr_y_q;
    logic       clr_done_q;
`endif

    logic [3:0] move_req, grant_mask;
    logic [1:0] grant;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_w, sel_col;

    // Fixed-priority grant (bullet > player > enemy) and the granted sprite's live inputs.
    always_comb begin
        move_req = {1'b0, bullet_move, enemy_move, player_move};
        if (pending_q[SP_BULLET])      grant = SP_BULLET;
        else if (pending_q[SP_PLAYER]) grant = SP_PLAYER;
        else                           grant = SP_ENEMY;
        grant_mask = '0;
        if (state_q == StIdle && |pending_q) grant_mask[grant] = 1'b1;
        case (job_id_q)
            SP_BULLET: begin
                sel_x = bulletX; sel_y = bulletY; sel_w = 3'd1; sel_col = BULLET_COLOUR;
            end
            SP_PLAYER: begin
                sel_x = playerX; sel_y = playerY; sel_w = PW; sel_col = PLAYER_COLOUR;
            end
            default: begin
                sel_x   = enemyX;
                sel_y   = enemyY;
                sel_w   = (enemy_width == 3'd0) ? 3'd1 : enemy_width;
                sel_col = (enemy_color == 3'd0) ? BG_COLOUR : enemy_color;
            end
        endcase
    end

    logic [2:0] cur_w, nxt_dx, nxt_dy;
    logic       sweep_last;

    // Row-major footprint stepping: dx inner, dy outer.
    always_comb begin
        cur_w      = (state_q == StErase) ? old_w_q[job_id_q] : job_w_q;
        sweep_last = (dx_q == cur_w - 3'd1) && (dy_q == cur_w - 3'd1);
        if (dx_q == cur_w - 3'd1) begin
            nxt_dx = 3'd0;
            nxt_dy = dy_q + 3'd1;
        end else begin
            nxt_dx = dx_q + 3'd1;
            nxt_dy = dy_q;
        end
    end

    logic [7:0] em_bx;
    logic [6:0] em_by;
    logic [2:0] em_dx, em_dy, em_col;
    logic [8:0] em_x;
    logic [7:0] em_y;
    logic       em_on;

    // Pixel to present on the cycle after this edge; widened so off-screen sums never wrap.
    always_comb begin
        em_bx  = '0;
        em_by  = '0;
        em_dx  = '0;
        em_dy  = '0;
        em_col = BG_COLOUR;
        em_on  = 1'b0;
        case (state_q)
            StSnap: begin
                em_on = 1'b1;
                if (first_draw_q[job_id_q]) begin
                    em_bx = sel_x; em_by = sel_y; em_col = sel_col;
                end else begin
                    em_bx = old_x_q[job_id_q]; em_by = old_y_q[job_id_q];
                end
            end
            StErase: begin
                em_on = 1'b1;
                if (sweep_last) begin
                    em_bx = job_x_q; em_by = job_y_q; em_col = job_col_q;
                end else begin
                    em_bx = old_x_q[job_id_q]; em_by = old_y_q[job_id_q];
                    em_dx = nxt_dx; em_dy = nxt_dy;
                end
            end
            StDraw: begin
                em_on  = !sweep_last;
                em_bx  = job_x_q; em_by = job_y_q; em_col = job_col_q;
                em_dx  = nxt_dx; em_dy = nxt_dy;
            end
`ifdef SCREEN_CLEAR_EN
            StClear: begin
                em_on = !clr_done_q;
                em_bx = clr_x_q; em_by = clr_y_q;
            end
`endif
            default: ;
        endcase
        em_x = {1'b0, em_bx} + {6'd0, em_dx};
        em_y = {1'b0, em_by} + {5'd0, em_dy};
    end

    // Job FSM, sprite bookkeeping and registered plot outputs.
    always_ff @(posedge clk) begin
        if (!resetn || load_level) begin
`ifdef SCREEN_CLEAR_EN
            state_q    <= StClear;
            clr_x_q    <= '0;
            clr_y_q    <= '0;
            clr_done_q <= 1'b0;
`else
            state_q    <= StIdle;
`endif
            pending_q    <= 4'b0111;
            first_draw_q <= 4'b0111;
            job_id_q     <= '0;
            job_x_q      <= '0;
            job_y_q      <= '0;
            job_w_q      <= '0;
            job_col_q    <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            for (int i = 0; i < 4; i++) begin
                old_x_q[i] <= '0;
                old_y_q[i] <= '0;
                old_w_q[i] <= '0;
            end
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            // A pulse on the grant cycle wins over the clear, so it is never lost.
            pending_q <= (pending_q & ~grant_mask) | move_req;
            x         <= em_x[7:0];
            y         <= em_y[6:0];
            colour    <= em_col;
            plot      <= em_on && (em_x < SCREEN_W) && (em_y < SCREEN_H);
            unique case (state_q)
                StIdle: begin
                    if (|pending_q) begin
                        job_id_q <= grant;
                        state_q  <= StSnap;
                        busy     <= 1'b1;
                    end
                end
                StSnap: begin
                    job_x_q   <= sel_x;
                    job_y_q   <= sel_y;
                    job_w_q   <= sel_w;
                    job_col_q <= sel_col;
                    dx_q      <= '0;
                    dy_q      <= '0;
                    if (first_draw_q[job_id_q]) state_q <= StDraw;
                    else                        state_q <= StErase;
                end
                StErase: begin
                    if (sweep_last) begin
                        dx_q    <= '0;
                        dy_q    <= '0;
                        state_q <= StDraw;
                    end else begin
                        dx_q <= nxt_dx;
                        dy_q <= nxt_dy;
                    end
                end
                StDraw: begin
                    if (sweep_last) begin
                        old_x_q[job_id_q]      <= job_x_q;
                        old_y_q[job_id_q]      <= job_y_q;
                        old_w_q[job_id_q]      <= job_w_q;
                        first_draw_q[job_id_q] <= 1'b0;
                        state_q                <= StIdle;
                        busy                   <= 1'b0;
                    end else begin
                        dx_q <= nxt_dx;
                        dy_q <= nxt_dy;
                    end
                end
`ifdef SCREEN_CLEAR_EN
                StClear: begin
                    if (clr_done_q) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else begin
                        busy <= 1'b1;
                        if (clr_x_q == 8'd159) begin
                            clr_x_q <= '0;
                            if (clr_y_q == 7'd119) clr_done_q <= 1'b1;
                            else                   clr_y_q    <= clr_y_q + 7'd1;
                        end else begin
                            clr_x_q <= clr_x_q + 8'd1;
                        end
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_controller.sv
// Directed bench for sprite_draw_controller: expected per-cycle plot streams are built into a
// vector table from footprint sweeps, then applied and compared cycle by cycle.
module tb_sprite_draw_controller;
    logic       clk = 1'b0;
    logic       resetn, load_level;
    logic       player_move, enemy_move, bullet_move;
    logic [7:0] playerX, enemyX, bulletX;
    logic [6:0] playerY, enemyY, bulletY;
    logic [2:0] enemy_width, enemy_color;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy;

    always #5 clk = ~clk;

    sprite_draw_controller dut (
        .clk(clk), .resetn(resetn), .load_level(load_level),
        .player_move(player_move), .playerX(playerX), .playerY(playerY),
        .enemy_move(enemy_move), .enemyX(enemyX), .enemyY(enemyY),
        .enemy_width(enemy_width), .enemy_color(enemy_color),
        .bullet_move(bullet_move), .bulletX(bulletX), .bulletY(bulletY),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
    );

    typedef struct {
        logic       pm, em, bm;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       plot, busy, chk;
    } vec_t;

    vec_t  vq[$];
    int    checks = 0;
    int    errors = 0;
    string phase;

    function automatic void add(input logic pm, em, bm, input int px, py,
                                input logic [2:0] col, input logic pl, bz, chk);
        vec_t v;
        v.pm = pm; v.em = em; v.bm = bm;
        v.x = 8'(px); v.y = 7'(py); v.col = col;
        v.plot = pl; v.busy = bz; v.chk = chk;
        vq.push_back(v);
    endfunction

    function automatic void add_idle();
        add(0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    endfunction

    function automatic void add_snap();
        add(0, 0, 0, 0, 0, 3'b000, 0, 1, 0);
    endfunction

    function automatic void add_pulse(input logic pm, em, bm);
        add(pm, em, bm, 0, 0, 3'b000, 0, 0, 0);
    endfunction

    // Row-major w*w footprint; off-screen pixels still take a cycle but must not plot.
    function automatic void add_sweep(input int x0, y0, w, input logic [2:0] col);
        for (int dy = 0; dy < w; dy++) begin
            for (int dx = 0; dx < w; dx++) begin
                logic on;
                on = (x0 + dx < 160) && (y0 + dy < 120);
                add(0, 0, 0, x0 + dx, y0 + dy, col, on, 1, on);
            end
        end
    endfunction

    task automatic run_vecs();
        for (int i = 0; i < vq.size(); i++) begin
            player_move = vq[i].pm;
            enemy_move  = vq[i].em;
            bullet_move = vq[i].bm;
            @(negedge clk);
            checks++;
            if (plot !== vq[i].plot || busy !== vq[i].busy ||
                (vq[i].chk && (x !== vq[i].x || y !== vq[i].y || colour !== vq[i].col))) begin
                errors++;
                $display("FAIL %s[%0d]: got x=%0d y=%0d c=%b plot=%b busy=%b, want %s x=%0d y=%0d c=%b plot=%b busy=%b",
                         phase, i, x, y, colour, plot, busy, vq[i].chk ? "pixel" : "ctrl",
                         vq[i].x, vq[i].y, vq[i].col, vq[i].plot, vq[i].busy);
            end
        end
        player_move = 0;
        enemy_move  = 0;
        bullet_move = 0;
        vq.delete();
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd0 || plot !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d c=%b plot=%b busy=%b, want all zero",
                     name, x, y, colour, plot, busy);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 0; load_level = 0;
        player_move = 0; enemy_move = 0; bullet_move = 0;
        bulletX = 8'd81; bulletY = 7'd116;
        playerX = 8'd80; playerY = 7'd115;
        enemyX = 8'd10; enemyY = 7'd10; enemy_width = 3'd4; enemy_color = 3'b111;
        repeat (3) @(negedge clk);
        check_reset("reset");

        // Power-up: every sprite pending and first-drawn, served bullet > player > enemy.
        phase = "init";
        resetn = 1;
        add_snap(); add_sweep(81, 116, 1, 3'b110); add_idle();
        add_snap(); add_sweep(80, 115, 3, 3'b010); add_idle();
        add_snap(); add_sweep(10, 10, 4, 3'b111); add_idle(); add_idle();
        run_vecs();

        // Player shift: 1 + 9 erase + 9 draw busy cycles.
        phase = "player_move";
        playerX = 8'd81;
        add_pulse(1, 0, 0); add_snap();
        add_sweep(80, 115, 3, 3'b000); add_sweep(81, 115, 3, 3'b010);
        add_idle(); add_idle();
        run_vecs();

        // Simultaneous pulses: bullet job finishes before player job, then nothing pending.
        phase = "dual_move";
        bulletX = 8'd90; bulletY = 7'd50; playerY = 7'd20;
        add_pulse(1, 0, 1); add_snap();
        add_sweep(81, 116, 1, 3'b000); add_sweep(90, 50, 1, 3'b110); add_idle();
        add_snap(); add_sweep(81, 115, 3, 3'b000); add_sweep(81, 20, 3, 3'b010);
        add_idle(); add_idle(); add_idle();
        run_vecs();

        // Destroyed enemy draws in background colour; a bullet pulse mid-job is kept.
        phase = "enemy_dead";
        enemyX = 8'd20; enemy_color = 3'b000;
        add_pulse(0, 1, 0); add_snap();
        add_sweep(10, 10, 4, 3'b000); add_sweep(20, 10, 4, 3'b000); add_idle();
        add_snap(); add_sweep(90, 50, 1, 3'b000); add_sweep(90, 50, 1, 3'b110);
        add_idle(); add_idle();
        vq[5].bm = 1'b1;
        run_vecs();

        // load_level acts as reset; enemy at x=158 is clipped on its right half.
        phase = "load_clip";
        load_level = 1; enemyX = 8'd158; enemy_color = 3'b101;
        @(negedge clk);
        check_reset("load_level");
        load_level = 0;
        add_snap(); add_sweep(90, 50, 1, 3'b110); add_idle();
        add_snap(); add_sweep(81, 20, 3, 3'b010); add_idle();
        add_snap(); add_sweep(158, 10, 4, 3'b101); add_idle(); add_idle();
        run_vecs();

        // Reset during the player draw sweep aborts the job outright.
        phase = "abort";
        playerX = 8'd100;
        add_pulse(1, 0, 0); add_snap();
        add_sweep(81, 20, 3, 3'b000); add_sweep(100, 20, 3, 3'b010);
        repeat (6) void'(vq.pop_back());
        run_vecs();
        resetn = 0;
        @(negedge clk);
        check_reset("reset_mid_draw");
        resetn = 1;
        phase = "redraw";
        add_snap(); add_sweep(90, 50, 1, 3'b110); add_idle();
        add_snap(); add_sweep(100, 20, 3, 3'b010); add_idle();
        add_snap(); add_sweep(158, 10, 4, 3'b101); add_idle(); add_idle();
        run_vecs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
